cla_sub_seq: RTL

- Multi-cycle wide subtractor that computes A - B - bin. It processes one 4-bit nibble per cycle through a carry-lookahead slice (A + ~B + ~bin) and keeps the borrow in a register between nibbles.
- It is the subtract/borrow counterpart of the team's 4-bit lookahead adder.
- It sits in datapaths that need wide differences at low area, with valid/ready handshakes on both input and output.

---
 rtl/cla_sub_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cla_sub_seq.sv
// Multi-cycle wide subtractor: computes a - b - bin one nibble per cycle through a 4-bit lookahead slice.
// Optional macro SUB_OVF_FLAG_EN adds the signed-overflow output o_ovf.
module cla_sub_seq #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout,
    output logic             o_zero
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_nb;
    logic             r_carry;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_zero;
    logic             r_ovf;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_nb_nib;
    logic [3:0]       w_p;
    logic [3:0]       w_g;
    logic [4:0]       w_c;
    logic [3:0]       w_sum;
    logic [WIDTH-1:0] w_diff_next;
    logic             w_last;

    // Select the active nibble and merge the slice result into the partial difference.
    always_comb begin
        w_a_nib     = '0;
        w_nb_nib    = '0;
        w_diff_next = r_diff;
        for (int n = 0; n < NIB; n++) begin
            if (r_k == KW'(n)) begin
                w_a_nib  = r_a[4*n +: 4];
                w_nb_nib = r_nb[4*n +: 4];
            end
        end

        w_p = w_a_nib ^ w_nb_nib;
        w_g = w_a_nib & w_nb_nib;

        // Carries expanded from c0 only, so no ripple between bit positions.
        w_c[0] = r_carry;
        w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
        w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

        w_sum = w_p ^ w_c[3:0];

        for (int n = 0; n < NIB; n++) begin
            if (r_k == KW'(n)) begin
                w_diff_next[4*n +: 4] = w_sum;
            end
        end

        w_last = (r_k == KW'(NIB - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_a     <= '0;
            r_nb    <= '0;
            r_carry <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_a     <= i_a;
                        r_nb    <= ~i_b;
                        r_carry <= ~i_bin;
                        r_k     <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_diff  <= w_diff_next;
                    r_carry <= w_c[4];
                    r_k     <= r_k + 1'b1;
                    if (w_last) begin
                        // Subtraction carry-out is the inverse of the borrow.
                        r_bout  <= ~w_c[4];
                        r_zero  <= (w_diff_next == '0);
                        r_ovf   <= w_c[3] ^ w_c[4];
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_out_valid = (r_state == S_DONE);
    assign o_diff      = r_diff;
    assign o_bout      = r_bout;
    assign o_zero      = r_zero;

`ifdef SUB_OVF_FLAG_EN
    assign o_ovf = r_ovf;
`else
    logic w_ovf_unused;
    assign w_ovf_unused = r_ovf;
`endif

endmodule
